output_mod_effects: RTL and testbench
=====================================

# output_mod_effects

Parametrised display-effect stage between the digit source and the 7-segment scan driver. It registers a packed vector of DIGITS hex digits and applies one of four run-time-selectable effects, each paced by an internal tick divider: pass-through, whole-display flicker, single-digit blink, and digit rotation. It generalises the single-mode, fixed 16-bit flicker output modifier, and adds reset, a programmable rate and digit-level effects.

## Interface
- DIGITS, 4: number of digits on the display; must be ≥ 2.
- DIGIT_W, 4: bits per digit.
- TICK_DIV, 25_000_000: clk cycles per effect tick; must be ≥ 2.
- OFF_CODE, {DIGIT_W{1'b0}}: digit value driven in the "off" phase.

- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- digits_in  in  DIGITS*DIGIT_W  packed digits; digit 0 in the LSBs.
- mode  in  2  0=PASS, 1=FLICKER, 2=BLINK, 3=ROTATE.
- sel  in  clog2(DIGITS)  digit blanked in BLINK; values ≥ DIGITS blank nothing.
- digits_out  out  DIGITS*DIGIT_W  registered effect output.
- tick  out  1  one-cycle pulse at every effect tick.
- phase_on  out  1  current blink/flicker phase; 1 = on.

## Operation
- Tick counter cnt: counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered; it is high for the one cycle after cnt == TICK_DIV-1.
- phase_on toggles on each tick.
- Rotation offset rot counts 0..DIGITS-1. It advances modulo DIGITS on each tick, only in ROTATE mode.
- Per-mode output, registered every cycle:
  - PASS: digits_out = digits_in.
  - FLICKER: digits_out = digits_in when phase_on, else all digits = OFF_CODE.
  - BLINK: digit sel = OFF_CODE when !phase_on; all other digits = digits_in.
  - ROTATE: output digit i = input digit (i + rot) mod DIGITS, i.e. rotate toward digit 0. phase is ignored.
- Mode change is detected against a registered copy mode_q.
  - On the cycle mode != mode_q: cnt, rot and tick are cleared, phase_on is set to 1, and mode_q is updated.
  - The output is computed with the new mode using the cleared state (phase on, rot 0).
- digits_in and sel may change on any cycle. They are sampled every cycle, with no holding.

## Timing
- Reset, while rst_n = 0 at a clk edge: digits_out = 0, tick = 0, phase_on = 1, cnt = 0, rot = 0, mode_q = 0 (PASS).
- Reset asserted mid-effect takes priority over ticks and mode change.
  - The first post-reset cycle behaves as if a mode change to the current mode occurred.
- Latency: digits_in, mode and sel to digits_out is 1 cycle.
- Tick period: exactly TICK_DIV cycles.
  - The first tick after reset or a mode change follows TICK_DIV cycles later.
- phase_on and rot update in the same edge as the tick pulse rises.
  - The output shows the new phase/offset one cycle after tick is seen high.
- Simultaneous tick and mode change: the mode change wins. No toggle and no advance occur.
- rot wraps from DIGITS-1 to 0 on the next tick.
- Leaving ROTATE discards rot. Re-entering ROTATE starts at 0.

## Structure
- Package output_mod_pkg holds:
  - mode constants MODE_PASS / MODE_FLICKER / MODE_BLINK / MODE_ROTATE;
  - a clog2 helper function.
- Sub-module effect_tick_gen: parameter TICK_DIV; inputs clk, rst_n, clear; output tick. It contains cnt.
- Top level holds phase_on, rot, mode_q and the output mux/rotator. The rotator uses a generate loop over DIGITS.

## Test plan
Bench configuration: DIGITS=4, DIGIT_W=4, TICK_DIV=4, OFF_CODE=0.
- Reset: hold rst_n=0 for 3 cycles with digits_in=16'h1234 and mode=FLICKER.
  - Expected: digits_out=0, tick=0, phase_on=1.
  - After release: 16'h1234 appears one cycle later.
- PASS: digits_in steps 16'h0000→16'hBEEF.
  - Expected: digits_out follows with 1-cycle latency; tick pulses every 4 cycles; output is never blanked.
- FLICKER: digits_in=16'hAAAA.
  - Expected: digits_out alternates 16'hAAAA / 16'h0000 in 4-cycle runs.
  - A mode change to PASS mid-off-phase restores 16'hAAAA on the next cycle.
- BLINK: sel=2, digits_in=16'h1234.
  - Expected: digits_out alternates 16'h1234 / 16'h1034.
  - With sel=3: alternates 16'h1234 / 16'h0234.
- ROTATE: digits_in=16'h1234.
  - Expected: digits_out sequence 1234→4123→3412→2341→1234, one step per tick.
  - Wrap after 4 ticks.
- Mode change coinciding with a tick edge, and reset asserted mid-ROTATE.
  - Expected: no phase toggle or rotation step occurs.
  - Expected: the output restarts from the unrotated value, with the next tick exactly 4 cycles later.

Source files
------------

// File: rtl/output_mod_effects_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : output_mod_pkg
//  Description : Shared constants and helpers for the display-effect stage.
//                Holds the run-time mode encodings and a constant-foldable
//                ceil(log2) used to size select and counter fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package output_mod_pkg;

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_FLICKER = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_ROTATE  = 2'd3;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_mod_effects_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : effect_tick_gen
//  Description : Free-running effect tick divider. Counts 0..TICK_DIV-1 and
//                emits a registered one-cycle tick on the cycle after the
//                terminal count. A clear restarts the count from zero and
//                suppresses any tick due on that edge.
//  Ports       : clk        - system clock
//                rst_n      - synchronous active-low reset
//                clear      - restart the tick period (mode change)
//                tick       - registered one-cycle tick pulse
//                tick_next  - high when tick will rise on the coming edge
//  Revision    : 1.0 - initial release
// ============================================================================
module effect_tick_gen
    import output_mod_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int CNT_W = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Lets the parent update phase/rotation on the same edge that tick rises.
    assign tick_next = (r_cnt == c_cnt_max) && !clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt <= '0;
            tick  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_mod_effects.sv
`default_nettype none
// ============================================================================
//  Module      : output_mod_effects
//  Description : Display-effect stage between the digit source and the
//                7-segment scan driver. Registers DIGITS packed digits and
//                applies PASS / FLICKER / BLINK / ROTATE, paced by a tick.
//  Ports       : clk        - system clock
//                rst_n      - synchronous active-low reset
//                digits_in  - packed digits, digit 0 in the LSBs
//                mode       - effect select (see output_mod_pkg)
//                sel        - digit blanked in BLINK (>= DIGITS: none)
//                digits_out - registered effect output
//                tick       - one-cycle pulse per effect tick
//                phase_on   - current flicker/blink phase, 1 = on
//  Revision    : 1.0 - initial release
// ============================================================================
module output_mod_effects
    import output_mod_pkg::*;
#(
    parameter int                 DIGITS   = 4,
    parameter int                 DIGIT_W  = 4,
    parameter int                 TICK_DIV = 25_000_000,
    parameter logic [DIGIT_W-1:0] OFF_CODE = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGITS*DIGIT_W-1:0]     digits_in,
    input  logic [1:0]                    mode,
    input  logic [clog2(DIGITS)-1:0]      sel,
    output logic [DIGITS*DIGIT_W-1:0]     digits_out,
    output logic                          tick,
    output logic                          phase_on
);

    localparam int DATA_W = DIGITS * DIGIT_W;
    localparam int ROT_W  = clog2(DIGITS);
    localparam logic [ROT_W-1:0] c_rot_max = ROT_W'(DIGITS - 1);

    logic [1:0]       r_mode_q;
    logic             r_first;
    logic             r_phase_on;
    logic [ROT_W-1:0] r_rot;

    logic             w_clear;
    logic             w_tick_next;
    logic             w_phase_eff;
    logic [ROT_W-1:0] w_rot_eff;
    logic [DATA_W-1:0] w_next;
    wire  [DATA_W-1:0] w_rotated;
    wire  [DATA_W-1:0] w_blinked;

    // The first cycle out of reset is treated like a mode change so the tick
    // period always starts from a clean count.
    assign w_clear     = r_first || (mode != r_mode_q);
    // A mode change computes the output from the cleared state.
    assign w_phase_eff = w_clear ? 1'b1 : r_phase_on;
    assign w_rot_eff   = w_clear ? '0   : r_rot;
    assign phase_on    = r_phase_on;

    effect_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .tick      (tick),
        .tick_next (w_tick_next)
    );

    // Per-digit rotator and blink blanking. Output digit i takes input digit
    // (i + rot) mod DIGITS, rotating content toward digit 0.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [DIGIT_W-1:0] w_cand [DIGITS];

        for (genvar gr = 0; gr < DIGITS; gr++) begin : g_cand
            assign w_cand[gr] = digits_in[((gi + gr) % DIGITS)*DIGIT_W +: DIGIT_W];
        end

        assign w_rotated[gi*DIGIT_W +: DIGIT_W] = w_cand[w_rot_eff];
        assign w_blinked[gi*DIGIT_W +: DIGIT_W] =
            (!w_phase_eff && (int'(sel) == gi)) ? OFF_CODE
                                                : digits_in[gi*DIGIT_W +: DIGIT_W];
    end

    always_comb begin
        w_next = digits_in;
        case (mode)
            MODE_FLICKER: w_next = w_phase_eff ? digits_in : {DIGITS{OFF_CODE}};
            MODE_BLINK:   w_next = w_blinked;
            MODE_ROTATE:  w_next = w_rotated;
            default:      w_next = digits_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_out <= '0;
            r_phase_on <= 1'b1;
            r_rot      <= '0;
            r_mode_q   <= MODE_PASS;
            r_first    <= 1'b1;
        end else begin
            digits_out <= w_next;
            r_mode_q   <= mode;
            r_first    <= 1'b0;
            if (w_clear) begin
                r_phase_on <= 1'b1;
                r_rot      <= '0;
            end else if (w_tick_next) begin
                r_phase_on <= ~r_phase_on;
                if (r_mode_q == MODE_ROTATE) begin
                    r_rot <= (r_rot == c_rot_max) ? '0 : r_rot + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_mod_effects.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_mod_effects
//  Description : Self-checking bench for output_mod_effects (DIGITS=4,
//                DIGIT_W=4, TICK_DIV=4, OFF_CODE=0). Each directed vector
//                drives one cycle of inputs and queues the hand-computed
//                outputs expected after the following clock edge; a monitor
//                pops and compares after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_mod_effects;
    import output_mod_pkg::*;

    localparam logic [1:0] PS = MODE_PASS;
    localparam logic [1:0] FL = MODE_FLICKER;
    localparam logic [1:0] BL = MODE_BLINK;
    localparam logic [1:0] RO = MODE_ROTATE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [15:0] digits_out;
    logic        tick;
    logic        phase_on;

    always #5 clk = ~clk;

    output_mod_effects #(
        .DIGITS   (4),
        .DIGIT_W  (4),
        .TICK_DIV (4),
        .OFF_CODE (4'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .mode       (mode),
        .sel        (sel),
        .digits_out (digits_out),
        .tick       (tick),
        .phase_on   (phase_on)
    );

    typedef struct {
        logic [15:0] d;
        logic        t;
        logic        p;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_issued = 0;

    // One cycle: inputs applied before the next rising edge, expected outputs
    // are those visible just after that edge.
    task automatic v(input logic r, input logic [1:0] m, input logic [1:0] s,
                     input logic [15:0] din, input logic [15:0] ed,
                     input logic et, input logic ep);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        mode      = m;
        sel       = s;
        digits_in = din;
        e.d  = ed;
        e.t  = et;
        e.p  = ep;
        e.id = n_issued;
        n_issued++;
        sb_q.push_back(e);
    endtask

    task automatic rep(input int n, input logic r, input logic [1:0] m,
                       input logic [1:0] s, input logic [15:0] din,
                       input logic [15:0] ed, input logic et, input logic ep);
        for (int k = 0; k < n; k++) begin
            v(r, m, s, din, ed, et, ep);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (digits_out !== e.d || tick !== e.t || phase_on !== e.p) begin
                    n_err++;
                    $display("FAIL vec %0d out/tick/phase: got %h/%b/%b, expected %h/%b/%b",
                             e.id, digits_out, tick, phase_on, e.d, e.t, e.p);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        mode      = FL;
        sel       = 2'd0;
        digits_in = 16'h1234;

        // Reset held with FLICKER selected, then release.
        rep(3, 1'b0, FL, 2'd0, 16'h1234, 16'h0000, 1'b0, 1'b1);
        rep(4, 1'b1, FL, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, FL, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0);
        v  (   1'b1, FL, 2'd0, 16'h1234, 16'h0000, 1'b0, 1'b0);

        // PASS: follows input, never blanked through the off phase.
        v(1'b1, PS, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        v(1'b1, PS, 2'd0, 16'h1111, 16'h1111, 1'b0, 1'b1);
        v(1'b1, PS, 2'd0, 16'h2222, 16'h2222, 1'b0, 1'b1);
        v(1'b1, PS, 2'd0, 16'h3333, 16'h3333, 1'b0, 1'b1);
        v(1'b1, PS, 2'd0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0);
        v(1'b1, PS, 2'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        v(1'b1, PS, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        v(1'b1, PS, 2'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        v(1'b1, PS, 2'd0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1);
        v(1'b1, PS, 2'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1);

        // FLICKER on AAAA, then PASS in the middle of an off phase.
        rep(4, 1'b1, FL, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b1);
        v  (   1'b1, FL, 2'd0, 16'hAAAA, 16'hAAAA, 1'b1, 1'b0);
        rep(3, 1'b1, FL, 2'd0, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        v  (   1'b1, FL, 2'd0, 16'hAAAA, 16'h0000, 1'b1, 1'b1);
        rep(3, 1'b1, FL, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b1);
        v  (   1'b1, FL, 2'd0, 16'hAAAA, 16'hAAAA, 1'b1, 1'b0);
        v  (   1'b1, FL, 2'd0, 16'hAAAA, 16'h0000, 1'b0, 1'b0);
        v  (   1'b1, PS, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b1);

        // BLINK sel=2, then sel=3 without a mode change.
        rep(4, 1'b1, BL, 2'd2, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, BL, 2'd2, 16'h1234, 16'h1234, 1'b1, 1'b0);
        rep(3, 1'b1, BL, 2'd2, 16'h1234, 16'h1034, 1'b0, 1'b0);
        v  (   1'b1, BL, 2'd2, 16'h1234, 16'h1034, 1'b1, 1'b1);
        v  (   1'b1, BL, 2'd2, 16'h1234, 16'h1234, 1'b0, 1'b1);
        rep(2, 1'b1, BL, 2'd3, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, BL, 2'd3, 16'h1234, 16'h1234, 1'b1, 1'b0);
        rep(3, 1'b1, BL, 2'd3, 16'h1234, 16'h0234, 1'b0, 1'b0);
        v  (   1'b1, BL, 2'd3, 16'h1234, 16'h0234, 1'b1, 1'b1);
        v  (   1'b1, BL, 2'd3, 16'h1234, 16'h1234, 1'b0, 1'b1);

        // ROTATE: one step per tick, wrapping after four ticks.
        rep(4, 1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0);
        rep(3, 1'b1, RO, 2'd0, 16'h1234, 16'h4123, 1'b0, 1'b0);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h4123, 1'b1, 1'b1);
        rep(3, 1'b1, RO, 2'd0, 16'h1234, 16'h3412, 1'b0, 1'b1);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h3412, 1'b1, 1'b0);
        rep(3, 1'b1, RO, 2'd0, 16'h1234, 16'h2341, 1'b0, 1'b0);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h2341, 1'b1, 1'b1);
        rep(3, 1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);

        // Mode change to BLINK on the edge a tick was due: no tick, no toggle.
        v  (   1'b1, BL, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        rep(3, 1'b1, BL, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, BL, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0);
        rep(3, 1'b1, BL, 2'd0, 16'h1234, 16'h1230, 1'b0, 1'b0);

        // Back into ROTATE on a tick-due edge: restarts unrotated.
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        rep(3, 1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0);
        rep(3, 1'b1, RO, 2'd0, 16'h1234, 16'h4123, 1'b0, 1'b0);

        // Reset on a tick-due edge mid-ROTATE, then release.
        rep(2, 1'b0, RO, 2'd0, 16'h1234, 16'h0000, 1'b0, 1'b1);
        rep(4, 1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b1);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0);
        v  (   1'b1, RO, 2'd0, 16'h1234, 16'h4123, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
